// File: rtl/d_mem_icecream_v2_pkg.sv
// Shared constants for the icecream v2 data (tape) memory.
// Bus direction encodings used by the core's data port.
package d_mem_icecream_v2_pkg;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  function automatic int ram_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/d_mem_icecream_v2_if.sv
// Core data-port bus: req/ack transaction plus clear/init sideband.
// master = bfcpu core, slave = data memory.
interface d_mem_icecream_v2_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) ();

  logic              d_req;
  logic              d_dir;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_clear;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  logic              d_init_done;

  modport master (
    output d_req, d_dir, d_addr, d_wdata, d_clear,
    input  d_ack, d_rdata, d_err, d_init_done
  );

  modport slave (
    input  d_req, d_dir, d_addr, d_wdata, d_clear,
    output d_ack, d_rdata, d_err, d_init_done
  );

endinterface

// File: rtl/d_mem_sp_ram.sv
// Single-port RAM, sync write and registered sync read.
// No reset on array or read register so it maps onto block RAM.
module d_mem_sp_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/d_mem_icecream_v2.sv
// Icecream v2 tape memory: req/ack FSM, range check, RAM wrapper.
// Optional zero-clear sweep enabled by defining D_MEM_CLEAR_EN.
module d_mem_icecream_v2
  import d_mem_icecream_v2_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  d_mem_icecream_v2_if.slave   bus
);

  localparam int AW = ram_aw(DEPTH);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

`ifdef D_MEM_CLEAR_EN
  localparam state_t RST_ST = ST_CLEAR;
`else
  localparam state_t RST_ST = ST_IDLE;
`endif

  if (DEPTH > (2 ** ADDR_W)) begin : g_depth_chk
    $error("DEPTH exceeds address space of d_addr");
  end

  state_t            state;
  logic              ack;
  logic              err;
  logic              rd_zero;
  logic              in_range;
  logic              take;
  logic              ram_we;
  logic              ram_re;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;

  assign in_range = 32'(bus.d_addr) < DEPTH;
  assign take     = (state == ST_IDLE) && bus.d_req;

`ifdef D_MEM_CLEAR_EN
  logic [AW-1:0] ptr;
  logic          sweep;

  assign sweep = (state == ST_CLEAR);

  // Sweep owns the RAM port; the core is locked out meanwhile.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = bus.d_addr[AW-1:0];
    ram_wdata = bus.d_wdata;
    if (sweep) begin
      ram_we    = 1'b1;
      ram_addr  = ptr;
      ram_wdata = '0;
    end else begin
      ram_we = take && in_range
             && (bus.d_dir == DIR_WRITE);
    end
  end
`else
  logic clear_unused;

  assign clear_unused = bus.d_clear;
  assign ram_addr     = bus.d_addr[AW-1:0];
  assign ram_wdata    = bus.d_wdata;
  assign ram_we       = take && in_range
                      && (bus.d_dir == DIR_WRITE);
`endif

  assign ram_re = take && in_range
                && (bus.d_dir == DIR_READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RST_ST;
      ack     <= 1'b0;
      err     <= 1'b0;
      rd_zero <= 1'b1;
`ifdef D_MEM_CLEAR_EN
      ptr     <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.d_req) begin
            state <= ST_ACK;
            ack   <= 1'b1;
            err   <= !in_range;
            if (bus.d_dir == DIR_READ) begin
              rd_zero <= !in_range;
            end
          end
`ifdef D_MEM_CLEAR_EN
          else if (bus.d_clear) begin
            state <= ST_CLEAR;
            ptr   <= '0;
          end
`endif
        end
        ST_ACK: begin
          state <= ST_IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
        end
`ifdef D_MEM_CLEAR_EN
        ST_CLEAR: begin
          if (ptr == AW'(DEPTH - 1)) begin
            state <= ST_IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + AW'(1);
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

  // Read register holds; rd_zero masks out-of-range and reset.
  assign bus.d_rdata     = rd_zero ? '0 : ram_q;
  assign bus.d_ack       = ack;
  assign bus.d_err       = err;
  assign bus.d_init_done = (state != ST_CLEAR);

  d_mem_sp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_d_mem_icecream_v2.sv
// Directed bench for d_mem_icecream_v2 (DATA_W=8, ADDR_W=8, DEPTH=64).
// Adapts clear-sweep checks to whether D_MEM_CLEAR_EN is defined.
module tb_d_mem_icecream_v2;
  import d_mem_icecream_v2_pkg::*;

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  d_mem_icecream_v2_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  d_mem_icecream_v2 #(
    .DATA_W (8),
    .ADDR_W (8),
    .DEPTH  (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Starts and ends at posedge+1; samples outputs in the ack cycle.
  task automatic txn(input logic dir,
                     input logic [7:0] addr,
                     input logic [7:0] wd,
                     input logic clr,
                     output logic ak,
                     output logic [7:0] rd,
                     output logic er);
    bus.d_req   = 1'b1;
    bus.d_dir   = dir;
    bus.d_addr  = addr;
    bus.d_wdata = wd;
    bus.d_clear = clr;
    @(posedge clk);
    #1;
    bus.d_clear = 1'b0;
    @(negedge clk);
    ak = bus.d_ack;
    rd = bus.d_rdata;
    er = bus.d_err;
    bus.d_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic       ak;
  logic [7:0] rd;
  logic       er;
  int         n;
  int         idle_k;
  int         ack_k;

  initial begin
    vecs        = 0;
    errs        = 0;
    rst_n       = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_dir   = DIR_READ;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(bus.d_ack), 0);
    chk("rst_rdata", 32'(bus.d_rdata), 0);
    chk("rst_err", 32'(bus.d_err), 0);
`ifdef D_MEM_CLEAR_EN
    chk("rst_init", 32'(bus.d_init_done), 0);
`else
    chk("rst_init", 32'(bus.d_init_done), 1);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef D_MEM_CLEAR_EN
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (bus.d_init_done && n == 0) n = i;
      if (n != 0) break;
    end
    chk("sweep_len", 32'(n), 64);
    for (int a = 0; a < 64; a++) begin
      txn(DIR_READ, 8'(a), 8'h00, 1'b0, ak, rd, er);
      chk("cell_zero", {23'd0, ak, rd}, {23'd1, 8'h00});
    end
`else
    chk("init_done", 32'(bus.d_init_done), 1);
`endif

    txn(DIR_WRITE, 8'd3, 8'hA5, 1'b0, ak, rd, er);
    chk("wr3_ack", 32'(ak), 1);
    chk("wr3_err", 32'(er), 0);
    chk("ack_drop", 32'(bus.d_ack), 0);

    txn(DIR_READ, 8'd3, 8'h00, 1'b0, ak, rd, er);
    chk("rd3_ack", 32'(ak), 1);
    chk("rd3_data", 32'(rd), 32'hA5);
    chk("rd3_err", 32'(er), 0);

    txn(DIR_WRITE, 8'd4, 8'h99, 1'b0, ak, rd, er);
    chk("wr_hold_rdata", 32'(rd), 32'hA5);

    txn(DIR_WRITE, 8'd6, 8'h11, 1'b0, ak, rd, er);
    txn(DIR_WRITE, 8'd70, 8'h77, 1'b0, ak, rd, er);
    chk("wr70_ack", 32'(ak), 1);
    chk("wr70_err", 32'(er), 1);
    chk("err_drop", 32'(bus.d_err), 0);

    txn(DIR_READ, 8'd6, 8'h00, 1'b0, ak, rd, er);
    chk("rd6_data", 32'(rd), 32'h11);

    txn(DIR_READ, 8'd70, 8'h00, 1'b0, ak, rd, er);
    chk("rd70_ack", 32'(ak), 1);
    chk("rd70_data", 32'(rd), 0);
    chk("rd70_err", 32'(er), 1);
    chk("rd70_hold", 32'(bus.d_rdata), 0);

    txn(DIR_READ, 8'd4, 8'h00, 1'b0, ak, rd, er);
    chk("rd4_data", 32'(rd), 32'h99);

    txn(DIR_WRITE, 8'd63, 8'h5A, 1'b0, ak, rd, er);
    chk("wr63_err", 32'(er), 0);
    txn(DIR_READ, 8'd63, 8'h00, 1'b0, ak, rd, er);
    chk("rd63_data", 32'(rd), 32'h5A);
    txn(DIR_READ, 8'd64, 8'h00, 1'b0, ak, rd, er);
    chk("rd64_err", 32'(er), 1);
    chk("rd64_data", 32'(rd), 0);

    txn(DIR_WRITE, 8'd10, 8'hFF, 1'b0, ak, rd, er);
    txn(DIR_READ, 8'd10, 8'h00, 1'b1, ak, rd, er);
    chk("req_beats_clr", 32'(rd), 32'hFF);
    chk("no_sweep", 32'(bus.d_init_done), 1);

    bus.d_clear = 1'b1;
    @(posedge clk);
    #1;
    bus.d_clear = 1'b0;
`ifdef D_MEM_CLEAR_EN
    bus.d_req  = 1'b1;
    bus.d_dir  = DIR_READ;
    bus.d_addr = 8'd10;
    idle_k = 0;
    ack_k  = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus.d_init_done && idle_k == 0) idle_k = k;
      if (bus.d_ack) begin
        ack_k = k;
        break;
      end
    end
    rd = bus.d_rdata;
    bus.d_req = 1'b0;
    @(posedge clk);
    #1;
    chk("clr_idle_at", 32'(idle_k), 65);
    chk("clr_ack_at", 32'(ack_k), 66);
    chk("clr_rd10", 32'(rd), 0);
`else
    txn(DIR_READ, 8'd10, 8'h00, 1'b0, ak, rd, er);
    chk("clr_ignored", 32'(rd), 32'hFF);
    chk("clr_init", 32'(bus.d_init_done), 1);

    bus.d_req   = 1'b1;
    bus.d_dir   = DIR_WRITE;
    bus.d_addr  = 8'd5;
    bus.d_wdata = 8'h3C;
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    bus.d_req = 1'b0;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.d_ack) n++;
    end
    chk("abort_no_ack", 32'(n), 0);
    chk("abort_rdata", 32'(bus.d_rdata), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    txn(DIR_READ, 8'd5, 8'h00, 1'b0, ak, rd, er);
    chk("abort_kept", 32'(rd), 32'h3C);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
